// File: rtl/cust_spike_detector_if.sv
// Sample-input and spike-event streams of the spike detector.
// Both directions use a valid/ready handshake: a transfer happens on a cycle
// where the producer's valid and the consumer's read are both high.
interface cust_spike_detector_if #(
  parameter int unsigned CHANNELS_PW2 = 7
);
  logic [15:0]             chan_in_sample;
  logic [CHANNELS_PW2-1:0] chan_in_num;
  logic                    chan_in_valid;
  logic                    chan_in_read;
  logic [CHANNELS_PW2-1:0] spike_num;
  logic                    spike_valid;
  logic                    spike_read;

  // Environment side: supplies samples, consumes spike events.
  modport master (
    output chan_in_sample, chan_in_num, chan_in_valid, spike_read,
    input  chan_in_read, spike_num, spike_valid
  );

  // Detector side: consumes samples, supplies spike events.
  modport slave (
    input  chan_in_sample, chan_in_num, chan_in_valid, spike_read,
    output chan_in_read, spike_num, spike_valid
  );
endinterface

// File: rtl/cust_spike_detector.sv
// Multi-channel threshold spike detector.
// Each channel must first see a sample above threshold (arming) before a
// sample at or below threshold raises an event; after an event the channel
// ignores the next `refractory` accepted samples. Events are presented one at
// a time on a single-entry output register with valid/read handshake.
module cust_spike_detector #(
  parameter int unsigned CHANNELS     = 1,
  parameter int unsigned CHANNELS_PW2 = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  cust_spike_detector_if.slave bus,
  input  logic [15:0]          threshold,
  input  logic [15:0]          refractory,
  input  logic                 enable,
  output logic [31:0]          spike_count
);

  // State is sized to the full channel-number space so any chan_in_num
  // indexes a real entry; entries at or above CHANNELS are never written.
  localparam int unsigned DEPTH = 32'd1 << CHANNELS_PW2;

  logic [15:0]             rc    [DEPTH];
  logic                    armed [DEPTH];

  logic                    ev_valid;
  logic [CHANNELS_PW2-1:0] ev_num;
  logic [31:0]             ev_count;

  logic                    in_read;
  logic                    in_range;
  logic                    take;
  logic [15:0]             cur_rc;
  logic                    cur_armed;
  logic                    crossing;
  logic                    fire;

  // Input is ready whenever the output slot is free or being emptied this cycle.
  assign in_read         = !reset && (!ev_valid || bus.spike_read);
  assign bus.chan_in_read = in_read;
  assign bus.spike_valid  = ev_valid;
  assign bus.spike_num    = ev_num;
  assign spike_count      = ev_count;

  // Decode the accepted sample against its channel's state.
  always_comb begin
    in_range  = 32'(bus.chan_in_num) < CHANNELS;
    take      = bus.chan_in_valid && in_read && in_range;
    cur_rc    = rc[bus.chan_in_num];
    cur_armed = armed[bus.chan_in_num];
    crossing  = $signed(bus.chan_in_sample) <= $signed(threshold);
    fire      = take && (cur_rc == '0) && crossing && cur_armed && enable;
  end

  // Per-channel refractory counter and arm flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rc[i]    <= '0;
        armed[i] <= 1'b0;
      end
    end else if (take) begin
      if (cur_rc != '0) begin
        rc[bus.chan_in_num] <= cur_rc - 16'd1;
      end else if (!crossing) begin
        armed[bus.chan_in_num] <= 1'b1;
      end else if (cur_armed && enable) begin
        armed[bus.chan_in_num] <= 1'b0;
        rc[bus.chan_in_num]    <= refractory;
      end
    end
  end

  // Output event slot and running event count; a new event overwrites a
  // slot that is being read in the same cycle, so nothing is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      ev_valid <= 1'b0;
      ev_num   <= '0;
      ev_count <= '0;
    end else if (fire) begin
      ev_valid <= 1'b1;
      ev_num   <= bus.chan_in_num;
      ev_count <= ev_count + 32'd1;
    end else if (bus.spike_read) begin
      ev_valid <= 1'b0;
    end
  end

endmodule

// File: doc/cust_spike_detector.md
CUST_SPIKE_DETECTOR -- requirements
Module: cust_spike_detector

Interface
REQ-001 The block SHALL take parameter CHANNELS, default 1: number of active channels, 1..128.
REQ-002 The block SHALL take parameter CHANNELS_PW2, default 7: width of the channel-number fields.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 chan_in_sample  input  16  filtered sample from the high-pass stage, two's-complement signed.
REQ-006 chan_in_num  input  CHANNELS_PW2  channel number of chan_in_sample.
REQ-007 chan_in_valid  input  1  upstream sample present.
REQ-008 chan_in_read  output  1  block ready; a sample transfers on a cycle with chan_in_valid=1 and chan_in_read=1.
REQ-009 threshold  input  16  signed detection threshold, sampled on every accepted sample.
REQ-010 refractory  input  16  refractory length in accepted samples of the same channel.
REQ-011 enable  input  1  detection enable; 0 suppresses new events.
REQ-012 spike_num  output  CHANNELS_PW2  channel of the pending spike event.
REQ-013 spike_valid  output  1  spike event pending.
REQ-014 spike_read  input  1  downstream ready; an event transfers on spike_valid=1 and spike_read=1.
REQ-015 spike_count  output  32  total events issued since reset, wrapping.

Function
REQ-016 The block SHALL keep per-channel state: a 16-bit refractory counter rc[ch] and a 1-bit armed flag armed[ch].
REQ-017 chan_in_read SHALL equal NOT reset AND (NOT spike_valid OR spike_read), combinationally.
REQ-018 On an accepted sample with chan_in_num >= CHANNELS, the sample SHALL be discarded with no state change and no event.
REQ-019 On an accepted sample for channel ch with rc[ch] != 0, rc[ch] SHALL decrement by 1 and no event SHALL be raised.
REQ-020 On an accepted sample for channel ch with rc[ch] = 0, the signed comparison sample <= threshold SHALL be a crossing; sample > threshold SHALL set armed[ch]=1.
REQ-021 A crossing with armed[ch]=1 and enable=1 SHALL raise an event, clear armed[ch], and load rc[ch] with refractory.
REQ-022 A crossing with armed[ch]=0 or enable=0 SHALL raise no event and leave rc[ch] and armed[ch] unchanged.
REQ-023 A raised event SHALL appear as spike_valid=1, spike_num=ch on the cycle after the sample is accepted (latency 1).
REQ-024 spike_valid and spike_num SHALL hold stable until the event transfers; spike_valid SHALL clear after transfer unless a new event is raised in the same cycle.
REQ-025 When an event transfers and a new event is raised in the same cycle, spike_valid SHALL stay 1 and spike_num SHALL update; no event SHALL be lost or duplicated.
REQ-026 spike_count SHALL increment by 1 on each cycle an event is raised, wrapping from 0xFFFFFFFF to 0.
REQ-027 refractory=0 SHALL mean no refractory period; re-arming still requires a sample above threshold.
REQ-028 Changes to threshold, refractory or enable SHALL take effect on the next accepted sample without disturbing running counters.

Reset
REQ-029 While reset=1: spike_valid=0, spike_num=0, spike_count=0, chan_in_read=0, every rc[ch]=0, every armed[ch]=0.
REQ-030 Reset asserted mid-event SHALL drop the pending event; the first cycle after reset deasserts SHALL have chan_in_read=1.
REQ-031 Channel state MAY be cleared by a sequential sweep of at most CHANNELS cycles after reset, provided chan_in_read stays 0 until the sweep completes.

Verification
REQ-032 CHANNELS=1, threshold=-100, refractory=0, enable=1, spike_read=1: samples 0, -150 -> one event, spike_num=0, one cycle after -150 accepted; spike_count=1.
REQ-033 Same setup: samples 0, -150, -150, 0, -150 -> exactly two events; the second -150 raises none (not re-armed).
REQ-034 CHANNELS=2, refractory=3: ch0 samples 0, -200, 0, -200, -200, 0, -200 -> events on the first -200 only and on the final -200 after rc reaches 0 and a re-arm sample.
REQ-035 Event pending, spike_read=0 for 5 cycles -> chan_in_read=0 throughout, spike_valid and spike_num stable; spike_read=1 -> transfer, chan_in_read returns to 1.
REQ-036 chan_in_num=5 with CHANNELS=2, sample=-32768 -> accepted, no event, spike_count unchanged; reset pulse with an event pending -> spike_valid=0, spike_count=0.
